rv_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the rv_core instruction-fetch port
//  and its load/store data port. Fixed data-over-fetch priority with an anti-starvation

---
 rtl/rv_mem_arbiter_pkg.sv | 23 ++
 rtl/rv_arb_owner_pipe.sv | 40 ++++
 rtl/rv_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_rv_mem_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_arbiter_pkg.sv
// rtl/rv_mem_arbiter_pkg.sv - shared constants and types for the rv_core memory arbiter
package rv_mem_arbiter_pkg;

  // Widths and depths of the core's memory map.
  localparam int DATA_WIDTH = 32;
  localparam int ROM_DEPTH  = 1024;

  // Default memory read latency (legal 1..4) and starvation limit (legal 1..15).
  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

  // Port-id encoding carried through the owner pipe.
  localparam logic PORT_IF = 1'b1;
  localparam logic PORT_D  = 1'b0;

  // Which requester owns the memory this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_sel_e;

endpackage

// File: rtl/rv_arb_owner_pipe.sv
// rtl/rv_arb_owner_pipe.sv - MEM_LAT-deep shift register tracking the owner of each read in flight
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset (clears every stage)
//   in_valid         a read was granted this cycle
//   in_port          port id of that read (PORT_IF / PORT_D)
//   out_valid        the read leaving the tail returns data this cycle
//   out_port         port id of the returning read
module rv_arb_owner_pipe #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_valid,
  input  logic in_port,
  output logic out_valid,
  output logic out_port
);

  logic [MEM_LAT-1:0] valid_q;
  logic [MEM_LAT-1:0] port_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      port_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      port_q[0]  <= in_port;
      for (int i = 1; i < MEM_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        port_q[i]  <= port_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[MEM_LAT-1];
  assign out_port  = port_q[MEM_LAT-1];

endmodule

// File: rtl/rv_mem_arbiter.sv
// rtl/rv_mem_arbiter.sv - shares one single-port memory between rv_core fetch and data ports
//
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   if_req_i/if_addr_i                 fetch read request
//   if_gnt_o/if_rvalid_o/if_rdata_o    fetch grant and in-order read return
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i   load/store request
//   d_gnt_o/d_rvalid_o/d_rdata_o       data grant and in-order read return
//   mem_en_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o   memory command
//   mem_rdata_i                        memory read data, MEM_LAT cycles after the grant edge
module rv_mem_arbiter
  import rv_mem_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_WIDTH,
  parameter int ADDR_W     = $clog2(ROM_DEPTH),
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  gnt_sel_e   sel;
  logic [3:0] starve_cnt;
  logic       pipe_in_valid;
  logic       pipe_in_port;
  logic       ret_valid;
  logic       ret_port;

  // Data wins unless fetch has already waited through STARVE_MAX data grants.
  // Grants are gated by rstn so every output is 0 while reset is held.
  always_comb begin
    sel = GNT_NONE;
    if (rstn) begin
      if (d_req_i && !(if_req_i && starve_cnt == STARVE_LIM)) begin
        sel = GNT_D;
      end else if (if_req_i) begin
        sel = GNT_IF;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (!if_req_i || sel == GNT_IF) begin
      starve_cnt <= '0;
    end else if (sel == GNT_D && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign if_gnt_o = (sel == GNT_IF);
  assign d_gnt_o  = (sel == GNT_D);

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (sel)
      GNT_IF: begin
        mem_en_o   = 1'b1;
        mem_be_o   = '1;
        mem_addr_o = if_addr_i;
      end
      GNT_D: begin
        mem_en_o    = 1'b1;
        mem_we_o    = d_we_i;
        mem_be_o    = d_be_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
      end
      default: ;
    endcase
  end

  // Writes complete at grant, so only reads occupy a pipe slot.
  assign pipe_in_valid = (sel == GNT_IF) || (sel == GNT_D && !d_we_i);
  assign pipe_in_port  = (sel == GNT_IF) ? PORT_IF : PORT_D;

  rv_arb_owner_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_owner_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (pipe_in_valid),
    .in_port   (pipe_in_port),
    .out_valid (ret_valid),
    .out_port  (ret_port)
  );

  assign if_rvalid_o = ret_valid && (ret_port == PORT_IF);
  assign d_rvalid_o  = ret_valid && (ret_port == PORT_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb/tb_rv_mem_arbiter.sv - directed self-checking bench for rv_mem_arbiter at MEM_LAT 1 and 3
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;

  logic        if_gnt1, if_rv1, d_gnt1, d_rv1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_be1;
  logic [9:0]  mem_addr1;

  logic        if_gnt3, if_rv3, d_gnt3, d_rv3, mem_en3, mem_we3;
  logic [31:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_be3;
  logic [9:0]  mem_addr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.DATA_W(32), .ADDR_W(10), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt1),
    .if_rvalid_o(if_rv1), .if_rdata_o(if_rdata1),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt1), .d_rvalid_o(d_rv1), .d_rdata_o(d_rdata1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_be_o(mem_be1),
    .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1)
  );

  rv_mem_arbiter #(.DATA_W(32), .ADDR_W(10), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rstn(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt3),
    .if_rvalid_o(if_rv3), .if_rdata_o(if_rdata3),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt3), .d_rvalid_o(d_rv3), .d_rdata_o(d_rdata3),
    .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_be_o(mem_be3),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
    end
  endtask

  // Expected per-cycle pattern for the MEM_LAT=3 back-to-back F D D F test.
  logic [6:0] exp_ifg = 7'b0001001; // bit c-1 for cycle c
  logic [6:0] exp_dg  = 7'b0000110;
  logic [6:0] exp_ifr = 7'b1001000;
  logic [6:0] exp_dr  = 7'b0110000;
  string      starve_seq = "DDDDFDDDDF";

  initial begin
    // 1. Reset held with both requests driven: every output of both instances is 0.
    rstn = 1'b0;
    if_req = 1'b1; if_addr = 10'h004;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 10'h010; d_wdata = 32'h1234_5678;
    mem_rdata1 = 32'hFFFF_FFFF; mem_rdata3 = 32'hFFFF_FFFF;
    #2;
    chk("rst_ctrl1", {54'd0, if_gnt1, if_rv1, d_gnt1, d_rv1, mem_en1, mem_we1, mem_be1}, 64'd0);
    chk("rst_rdata1", {if_rdata1, d_rdata1}, 64'd0);
    chk("rst_mem1", {22'd0, mem_addr1, mem_wdata1}, 64'd0);
    chk("rst_ctrl3", {54'd0, if_gnt3, if_rv3, d_gnt3, d_rv3, mem_en3, mem_we3, mem_be3}, 64'd0);
    chk("rst_rdata3", {if_rdata3, d_rdata3}, 64'd0);
    chk("rst_mem3", {22'd0, mem_addr3, mem_wdata3}, 64'd0);

    @(negedge clk);
    rstn = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("post_rst_rvalid_%0d", i), {60'd0, if_rv1, d_rv1, if_rv3, d_rv3}, 64'd0);
      @(negedge clk);
    end

    // 3. Both reads held 10 cycles: D D D D F D D D D F.
    for (int i = 0; i < 10; i++) begin
      if_req = 1'b1; if_addr = 10'h008;
      d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
      #1 chk($sformatf("starve_%0d", i), {62'd0, if_gnt1, d_gnt1},
             (starve_seq[i] == "F") ? 64'd2 : 64'd1);
      @(negedge clk);
    end
    idle(5);

    // 2. MEM_LAT=1 fetch: same-cycle grant, data next cycle.
    if_req = 1'b1; if_addr = 10'h004;
    #1;
    chk("fetch_gnt", {62'd0, if_gnt1, d_gnt1}, 64'd2);
    chk("fetch_mem_cmd", {56'd0, mem_en1, mem_we1, 2'b0, mem_be1}, {56'd0, 8'b1000_1111});
    chk("fetch_mem_addr", {54'd0, mem_addr1}, 64'h004);
    chk("fetch_mem_wdata", {32'd0, mem_wdata1}, 64'd0);
    @(negedge clk);
    if_req = 1'b0; mem_rdata1 = 32'hCAFE_0004;
    #1;
    chk("fetch_rvalid", {62'd0, if_rv1, d_rv1}, 64'd2);
    chk("fetch_rdata", {if_rdata1, d_rdata1}, {32'hCAFE_0004, 32'd0});
    @(negedge clk);
    #1 chk("fetch_rvalid_single", {62'd0, if_rv1, d_rv1}, 64'd0);
    idle(4);

    // 4. Write: driven through the mux, never returns data.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 10'h010; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_gnt", {62'd0, if_gnt1, d_gnt1}, 64'd1);
    chk("wr_mem_cmd", {58'd0, mem_en1, mem_we1, mem_be1}, {58'd0, 6'b11_0011});
    chk("wr_mem_addr", {54'd0, mem_addr1}, 64'h010);
    chk("wr_mem_wdata", {32'd0, mem_wdata1}, 64'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_req = 1'b0; d_we = 1'b0;
      #1 chk($sformatf("wr_no_rvalid_%0d", i), {62'd0, d_rv1, d_rv3}, 64'd0);
    end
    idle(4);

    // 5. MEM_LAT=3: F D D F back-to-back, returns three cycles later in order.
    for (int c = 1; c <= 7; c++) begin
      if_req = (c == 1 || c == 4);
      if_addr = 10'(c);
      d_req = (c == 2 || c == 3);
      d_we = 1'b0;
      d_addr = 10'(c + 16);
      mem_rdata3 = 32'h100 + 32'(c);
      #1;
      chk($sformatf("l3_gnt_c%0d", c), {62'd0, if_gnt3, d_gnt3},
          {62'd0, exp_ifg[c-1], exp_dg[c-1]});
      chk($sformatf("l3_rvalid_c%0d", c), {62'd0, if_rv3, d_rv3},
          {62'd0, exp_ifr[c-1], exp_dr[c-1]});
      chk($sformatf("l3_rdata_c%0d", c), {if_rdata3, d_rdata3},
          {exp_ifr[c-1] ? 32'h100 + 32'(c) : 32'd0, exp_dr[c-1] ? 32'h100 + 32'(c) : 32'd0});
      @(negedge clk);
    end
    idle(4);

    // 6. MEM_LAT=3: two reads in flight, reset pulse drops them.
    if_req = 1'b1; if_addr = 10'h030;
    #1 chk("rst6_gnt_f", {62'd0, if_gnt3, d_gnt3}, 64'd2);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h031;
    #1 chk("rst6_gnt_d", {62'd0, if_gnt3, d_gnt3}, 64'd1);
    @(negedge clk);
    rstn = 1'b0; if_req = 1'b1; d_req = 1'b1;
    #1 chk("rst6_held", {58'd0, if_gnt3, d_gnt3, if_rv3, d_rv3, mem_en3, mem_we3}, 64'd0);
    @(negedge clk);
    rstn = 1'b1; if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rst6_dropped_%0d", i), {62'd0, if_rv3, d_rv3}, 64'd0);
      @(negedge clk);
    end
    if_req = 1'b1; if_addr = 10'h040;
    #1 chk("rst6_new_gnt", {62'd0, if_gnt3, d_gnt3}, 64'd2);
    @(negedge clk);
    if_req = 1'b0;
    #1 chk("rst6_new_wait1", {62'd0, if_rv3, d_rv3}, 64'd0);
    @(negedge clk);
    #1 chk("rst6_new_wait2", {62'd0, if_rv3, d_rv3}, 64'd0);
    @(negedge clk);
    mem_rdata3 = 32'hBEEF_0040;
    #1;
    chk("rst6_new_rvalid", {62'd0, if_rv3, d_rv3}, 64'd2);
    chk("rst6_new_rdata", {if_rdata3, d_rdata3}, {32'hBEEF_0040, 32'd0});
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
